// File: rtl/seqgen_pkg.sv
// Shared types, constants and helpers for the serial pattern generator.
package seqgen_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic W_IDLE = 1'b0;

   // Out-of-range lengths (0 or wider than the pattern) send the full pattern.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
      return (len == 0 || len > pat_w) ? pat_w : len;
   endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Load handshake and serial output bundle of the sequence generator.
interface sequence_generator_if #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = $clog2(PAT_W) + 1,
   parameter int unsigned CNT_W = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] repeat_n;
   logic             w;
   logic             w_valid;
   logic             w_last;
   logic             busy;

   modport master (
      output load_valid, pattern, len, repeat_n,
      input  load_ready, w, w_valid, w_last, busy
   );

   modport slave (
      input  load_valid, pattern, len, repeat_n,
      output load_ready, w, w_valid, w_last, busy
   );
endinterface

// File: rtl/seqgen_bitcnt.sv
// Loadable down-counter with current and next-cycle terminal-count flags.
module seqgen_bitcnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         tc_c,
   output logic         tc_next_c
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (dec)
         count_d = count_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign tc_c      = (count_q == '0);
   assign tc_next_c = (count_d == '0);
endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: MSB-first shift-out with valid/last framing.
// Optional SEQGEN_REPEAT_EN builds the repeat counter; otherwise repeat_n is ignored.
module sequence_generator
   import seqgen_pkg::*;
#(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = $clog2(PAT_W) + 1,
   parameter int unsigned CNT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   sequence_generator_if.slave bus
);
   state_t           state_q, state_d;
   logic [PAT_W-1:0] sh_q, sh_d;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_m1_q;
   logic [PAT_W-1:0] pat_aligned;
   logic [LEN_W-1:0] len_m1;
   int unsigned      len_c;

   logic             accept;
   logic             bit_load, bit_dec, bit_tc, bit_tc_next;
   logic [LEN_W-1:0] bit_load_val;
   logic             rpt_wrap, rpt_tc, rpt_tc_next;

   logic             w_q, valid_q, last_q, busy_q, ready_q;
   logic             w_d, valid_d, last_d, ready_d;

   // Left-align the pattern so bit len-1 sits at the MSB of the window.
   assign len_c       = clamp_len(32'(bus.len), PAT_W);
   assign len_m1      = LEN_W'(len_c - 1);
   assign pat_aligned = bus.pattern << (PAT_W - len_c);
   assign accept      = bus.load_valid && ready_q;

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      bit_load     = 1'b0;
      bit_load_val = len_m1;
      bit_dec      = 1'b0;
      rpt_wrap     = 1'b0;
      if (accept) begin
         state_d  = SHIFT;
         sh_d     = pat_aligned;
         bit_load = 1'b1;
      end else if (state_q == SHIFT) begin
         if (!bit_tc) begin
            sh_d    = sh_q << 1;
            bit_dec = 1'b1;
         end else if (!rpt_tc) begin
            sh_d         = pat_q;
            bit_load     = 1'b1;
            bit_load_val = len_m1_q;
            rpt_wrap     = 1'b1;
         end else begin
            state_d = IDLE;
            sh_d    = '0;
         end
      end
   end

   seqgen_bitcnt #(.W(LEN_W)) u_bitcnt (
      .clk       (clk),
      .reset     (reset),
      .load      (bit_load),
      .load_val  (bit_load_val),
      .dec       (bit_dec),
      .tc_c      (bit_tc),
      .tc_next_c (bit_tc_next)
   );

`ifdef SEQGEN_REPEAT_EN
   seqgen_bitcnt #(.W(CNT_W)) u_rptcnt (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .load_val  (bus.repeat_n),
      .dec       (rpt_wrap),
      .tc_c      (rpt_tc),
      .tc_next_c (rpt_tc_next)
   );
`else
   logic [CNT_W:0] unused_rpt;
   assign unused_rpt  = {bus.repeat_n, rpt_wrap};
   assign rpt_tc      = 1'b1;
   assign rpt_tc_next = 1'b1;
`endif

   // Outputs are computed from next-state values so they can be flopped.
   assign valid_d = (state_d == SHIFT);
   assign w_d     = valid_d ? sh_d[PAT_W-1] : W_IDLE;
   assign last_d  = valid_d && bit_tc_next && rpt_tc_next;
   assign ready_d = !valid_d || last_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         pat_q    <= '0;
         len_m1_q <= '0;
         w_q      <= W_IDLE;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         if (accept) begin
            pat_q    <= pat_aligned;
            len_m1_q <= len_m1;
         end
         w_q     <= w_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign bus.w          = w_q;
   assign bus.w_valid    = valid_q;
   assign bus.w_last     = last_q;
   assign bus.busy       = busy_q;
   assign bus.load_ready = ready_q;
endmodule
